traffic_phase_scheduler: RTL and testbench



---
 rtl/traffic_phase_scheduler_if.sv | 23 ++
 rtl/traffic_phase_scheduler.sv | 74 +++++++
 tb/tb_traffic_phase_scheduler.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_phase_scheduler_if.sv
// traffic_phase_scheduler_if: sensor, preempt and signal-head bundle for the phase scheduler
interface traffic_phase_scheduler_if;
  logic x1;
  logic x2;
  logic x3;
  logic x4;
  logic emerg_req;
  logic [1:0] emerg_dir;
  logic [2:0] n_lights;
  logic [2:0] s_lights;
  logic [2:0] e_lights;
  logic [2:0] w_lights;
  logic [1:0] active_dir;
  logic green_valid;
  modport master (
    output x1, x2, x3, x4, emerg_req, emerg_dir,
    input n_lights, s_lights, e_lights, w_lights, active_dir, green_valid
  );
  modport slave (
    input x1, x2, x3, x4, emerg_req, emerg_dir,
    output n_lights, s_lights, e_lights, w_lights, active_dir, green_valid
  );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: actuated round-robin four-way phase scheduler with emergency preempt
module traffic_phase_scheduler #(
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 12,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 1,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst_a,
  traffic_phase_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GREEN, YELLOW, ALLRED} state_t;
  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] RED_LAST = CNT_W'(ALLRED_CYC - 1);
  state_t state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [3:0] pending, sensors, green_mask;
  logic [1:0] rr_ptr, dir, sel;
  logic [3:0][2:0] heads;
  logic other, demand, start;
  assign sensors = {bus.x4, bus.x3, bus.x2, bus.x1};
  assign other = |pending;
  assign demand = other | bus.emerg_req;
  assign start = state_next == GREEN && state != GREEN;
  assign green_mask = state == GREEN ? 4'b0001 << dir : 4'b0000;
  // grant: first pending approach after rr_ptr, overridden by the preempt direction
  always_comb begin
    sel = rr_ptr;
    for (int k = 4; k >= 1; k--) if (pending[rr_ptr + 2'(k)]) sel = rr_ptr + 2'(k);
    if (bus.emerg_req) sel = bus.emerg_dir;
  end
  // state, phase counter, sticky requests and served approach
  always_ff @(posedge clk or posedge rst_a)
    if (rst_a) begin
      state <= IDLE;
      cnt <= '0;
      pending <= '0;
      rr_ptr <= 2'd3;
      dir <= 2'd0;
    end else begin
      state <= state_next;
      cnt <= state_next != state || state == IDLE ? '0 : cnt == '1 ? cnt : cnt + CNT_W'(1);
      pending <= (pending | (sensors & ~green_mask)) & ~(start ? 4'b0001 << sel : 4'b0000);
      if (start) begin
        rr_ptr <= sel;
        dir <= sel;
      end
    end
  // phase sequencing: actuated green, fixed yellow and all-red, preempt shortcuts
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (demand) state_next = GREEN;
      GREEN: if (bus.emerg_req ? bus.emerg_dir != dir
                 : cnt >= MIN_LAST && other && (!sensors[dir] || cnt >= MAX_LAST)) state_next = YELLOW;
      YELLOW: if (cnt == YEL_LAST) state_next = ALLRED;
      ALLRED: if (cnt == RED_LAST) state_next = demand ? GREEN : IDLE;
    endcase
  end
  // head decode: only the served approach may leave red
  always_comb begin
    for (int i = 0; i < 4; i++)
      heads[i] = 2'(i) != dir || state == IDLE || state == ALLRED ? 3'b100 : state == GREEN ? 3'b001 : 3'b010;
    bus.n_lights = heads[0];
    bus.s_lights = heads[1];
    bus.e_lights = heads[2];
    bus.w_lights = heads[3];
    bus.active_dir = dir;
    bus.green_valid = state == GREEN;
  end
endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb_traffic_phase_scheduler: directed scenarios plus random traffic against a phase-timeline model
module tb_traffic_phase_scheduler;
  localparam int MIN_G = 4;
  localparam int MAX_G = 12;
  localparam int YEL = 3;
  localparam int RED = 1;
  logic clk = 1'b1;
  logic rst_a = 1'b0;
  int tests = 0;
  int fails = 0;
  traffic_phase_scheduler_if bus();
  traffic_phase_scheduler #(.MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G), .YELLOW_CYC(YEL), .ALLRED_CYC(RED), .CNT_W(8))
    dut (.clk(clk), .rst_a(rst_a), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] head(input int i);
    case (i)
      0: return bus.n_lights;
      1: return bus.s_lights;
      2: return bus.e_lights;
      default: return bus.w_lights;
    endcase
  endfunction

  // model: the intersection as a timeline of dark / go / amber / clear phases
  typedef enum {M_DARK, M_GO, M_AMBER, M_CLEAR} mphase_t;
  mphase_t m_phase = M_DARK;
  int m_dir = 0;
  int m_ptr = 3;
  int m_age = 0;
  int m_left = 0;
  bit m_pend[4] = '{default: 1'b0};

  function automatic int m_pick();
    for (int k = 1; k <= 4; k++) if (m_pend[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return m_ptr;
  endfunction

  function automatic logic [2:0] m_head(input int i);
    if (i == m_dir && m_phase == M_GO) return 3'b001;
    if (i == m_dir && m_phase == M_AMBER) return 3'b010;
    return 3'b100;
  endfunction

  task automatic m_step();
    bit s[4];
    bit any, dem, go;
    int g, old_dir;
    mphase_t was;
    s = '{bus.x1, bus.x2, bus.x3, bus.x4};
    any = m_pend[0] | m_pend[1] | m_pend[2] | m_pend[3];
    dem = any | bus.emerg_req;
    g = bus.emerg_req ? int'(bus.emerg_dir) : m_pick();
    was = m_phase;
    old_dir = m_dir;
    go = 1'b0;
    case (m_phase)
      M_DARK: go = dem;
      M_GO:
        if (bus.emerg_req ? int'(bus.emerg_dir) != m_dir
            : (m_age >= MIN_G - 1 && any && (!s[m_dir] || m_age >= MAX_G - 1))) begin
          m_phase = M_AMBER;
          m_left = YEL;
        end else m_age++;
      M_AMBER: begin
        m_left--;
        if (m_left == 0) begin
          m_phase = M_CLEAR;
          m_left = RED;
        end
      end
      M_CLEAR: begin
        m_left--;
        if (m_left == 0) begin
          if (dem) go = 1'b1;
          else m_phase = M_DARK;
        end
      end
    endcase
    for (int i = 0; i < 4; i++) if (s[i] && !(was == M_GO && i == old_dir)) m_pend[i] = 1'b1;
    if (go) begin
      m_phase = M_GO;
      m_dir = g;
      m_ptr = g;
      m_age = 0;
      m_pend[g] = 1'b0;
    end
  endtask

  always @(posedge clk or posedge rst_a)
    if (rst_a) begin
      m_phase = M_DARK;
      m_dir = 0;
      m_ptr = 3;
      m_age = 0;
      m_left = 0;
      m_pend = '{default: 1'b0};
    end else m_step();

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) check($sformatf("head%0d", i), int'(head(i)), int'(m_head(i)));
    check("active_dir", int'(bus.active_dir), m_dir);
    check("green_valid", int'(bus.green_valid), int'(m_phase == M_GO));
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] m);
    {bus.x4, bus.x3, bus.x2, bus.x1} = m;
    tick();
    {bus.x4, bus.x3, bus.x2, bus.x1} = 4'b0000;
  endtask

  task automatic wait_for(input int h, input logic [2:0] v, input int max);
    int n = 0;
    while (head(h) != v && n < max) begin
      tick();
      n++;
    end
    check($sformatf("reach_head%0d", h), int'(head(h)), int'(v));
  endtask

  task automatic run_len(input int h, input logic [2:0] v, input int max, output int len);
    len = 0;
    while (head(h) == v && len < max) begin
      len++;
      tick();
    end
  endtask

  task automatic check_dark(input string name);
    for (int i = 0; i < 4; i++) check($sformatf("%s_head%0d", name, i), int'(head(i)), 4);
    check($sformatf("%s_gv", name), int'(bus.green_valid), 0);
  endtask

  task automatic do_reset();
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    tick();
  endtask

  initial begin
    int len;
    {bus.x4, bus.x3, bus.x2, bus.x1} = 4'b0000;
    bus.emerg_req = 1'b0;
    bus.emerg_dir = 2'd0;
    #1 rst_a = 1'b1;
    #14 rst_a = 1'b0;
    repeat (50) tick();
    check_dark("idle50");
    check("idle50_dir", int'(bus.active_dir), 0);
    pulse(4'b0101);
    wait_for(0, 3'b001, 5);
    run_len(0, 3'b001, 50, len);
    check("n_green_len", len, 4);
    run_len(0, 3'b010, 50, len);
    check("n_yellow_len", len, 3);
    check("allred_n", int'(head(0)), 4);
    check("allred_e", int'(head(2)), 4);
    tick();
    check("e_green", int'(head(2)), 1);
    run_len(2, 3'b001, 30, len);
    check("e_rest_len", len, 30);
    pulse(4'b1011);
    wait_for(2, 3'b010, 5);
    rst_a = 1'b1;
    #1;
    check_dark("async_rst");
    tick();
    rst_a = 1'b0;
    repeat (10) tick();
    check_dark("post_rst");
    pulse(4'b1111);
    for (int h = 0; h < 4; h++) begin
      wait_for(h, 3'b001, 10);
      run_len(h, 3'b001, 30, len);
      check($sformatf("rr_green_len%0d", h), len, h < 3 ? 4 : 30);
    end
    bus.emerg_req = 1'b1;
    bus.emerg_dir = 2'd0;
    tick();
    run_len(3, 3'b010, 10, len);
    check("pre_yellow_len", len, 3);
    check("pre_allred_w", int'(head(3)), 4);
    check("pre_allred_n", int'(head(0)), 4);
    tick();
    run_len(0, 3'b001, 25, len);
    check("pre_hold_len", len, 25);
    bus.emerg_req = 1'b0;
    pulse(4'b0010);
    wait_for(1, 3'b001, 20);
    do_reset();
    bus.x1 = 1'b1;
    wait_for(0, 3'b001, 5);
    bus.x2 = 1'b1;
    tick();
    bus.x2 = 1'b0;
    run_len(0, 3'b001, 50, len);
    check("max_green_len", len + 1, 12);
    bus.x1 = 1'b0;
    run_len(0, 3'b010, 10, len);
    check("max_yellow_len", len, 3);
    tick();
    check("s_after_max", int'(head(1)), 1);
    for (int c = 0; c < 3000; c++) begin
      bus.x1 = $urandom_range(7) == 0;
      bus.x2 = $urandom_range(7) == 0;
      bus.x3 = $urandom_range(7) == 0;
      bus.x4 = $urandom_range(7) == 0;
      if ($urandom_range(39) == 0) begin
        bus.emerg_req = ~bus.emerg_req;
        bus.emerg_dir = 2'($urandom_range(3));
      end else if (bus.emerg_req && $urandom_range(59) == 0) bus.emerg_dir = 2'($urandom_range(3));
      if ($urandom_range(499) == 0) begin
        rst_a = 1'b1;
        #2 rst_a = 1'b0;
      end
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
